// File: rtl/pd_readout_adc_pkg.sv
// Shared types and the ADC transfer function for the photodiode readout path.
// The quantizer is a function so the reader and any reference model use one definition.
package pd_readout_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, ACQ, HOLD} rd_state_t;

    // floor((v-lo)/lsb), clamped to [0, 2**bits-1]; clip is set when either bound is hit.
    function automatic int pd_quantize(input real v, input real lo, input real hi,
                                       input int bits, output logic clip);
        real lsb;
        real x;
        int  maxc;
        int  code;
        maxc = (1 << bits) - 1;
        lsb  = (hi - lo) / real'(1 << bits);
        x    = $floor((v - lo) / lsb);
        clip = 1'b0;
        if (x < 0.0) begin
            clip = 1'b1;
            code = 0;
        end else if (x > real'(maxc)) begin
            clip = 1'b1;
            code = maxc;
        end else begin
            code = int'(x);
        end
        return code;
    endfunction

endpackage

// File: rtl/pd_readout_adc_if.sv
// Result handshake of the photodiode readout: averaged code, current estimate and
// saturation flag qualified by out_valid/out_ready.
interface pd_readout_adc_if #(
    parameter int ADC_BITS = 12
);
    logic                out_valid;
    logic                out_ready;
    logic [ADC_BITS-1:0] avg_code;
    real                 i_est;
    logic                sat;

    modport master (output out_valid, avg_code, i_est, sat, input out_ready);
    modport slave  (input out_valid, avg_code, i_est, sat, output out_ready);
endinterface

// File: rtl/pd_readout_adc_quantizer.sv
// Combinational real-to-code quantizer feeding the readout accumulator.
module pd_quantizer
    import pd_readout_pkg::*;
#(
    parameter int  ADC_BITS = 12,
    parameter real VREF_LO  = 0.0,
    parameter real VREF_HI  = 1.2
) (
    input  real                 vin,
    output logic [ADC_BITS-1:0] code,
    output logic                clip
);
    int code_full;

    always_comb begin
        code_full = pd_quantize(vin, VREF_LO, VREF_HI, ADC_BITS, clip);
        code      = ADC_BITS'(code_full);
    end
endmodule

// File: rtl/pd_readout_adc.sv
// Photodiode/TIA reader: quantizes vin every clk, block-averages NAVG samples after a
// settle window and offers the average plus a DC current estimate over valid/ready.
module pd_readout_adc
    import pd_readout_pkg::*;
#(
    parameter int  ADC_BITS   = 12,
    parameter int  NAVG       = 16,
    parameter int  SETTLE_CYC = 8,
    parameter real VREF_LO    = 0.0,
    parameter real VREF_HI    = 1.2,
    parameter real RF_OHM     = 20e3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  real                     vin,
    input  logic                    start,
    output logic [ADC_BITS-1:0]     last_code,
    output logic                    busy,
    pd_readout_adc_if.master        ob
);
    localparam int             LOG2N    = $clog2(NAVG);
    localparam int             ACC_W    = ADC_BITS + LOG2N;
    localparam real            LSB      = (VREF_HI - VREF_LO) / real'(2 ** ADC_BITS);
    localparam logic [8:0]     SET_LAST = 9'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);
    localparam logic [8:0]     ACQ_LAST = 9'(NAVG - 1);

    if ((NAVG < 1) || (NAVG > 256) || ((NAVG & (NAVG - 1)) != 0)) begin : g_bad_navg
        $fatal(1, "pd_readout_adc: NAVG must be a power of two in 1..256");
    end
    if (VREF_HI <= VREF_LO) begin : g_bad_vref
        $fatal(1, "pd_readout_adc: VREF_HI must exceed VREF_LO");
    end

    logic [ADC_BITS-1:0] q_code;
    logic                q_clip;

    pd_quantizer #(.ADC_BITS(ADC_BITS), .VREF_LO(VREF_LO), .VREF_HI(VREF_HI)) u_quant (
        .vin  (vin),
        .code (q_code),
        .clip (q_clip)
    );

    rd_state_t           state_q, state_d;
    logic [8:0]          cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                sat_acc_q, sat_acc_d;
    logic [ADC_BITS-1:0] last_code_q, last_code_d;
    logic [ADC_BITS-1:0] avg_code_q, avg_code_d;
    real                 i_est_q, i_est_d;
    logic                sat_q, sat_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic [ACC_W-1:0]    acc_sum;
    logic [ADC_BITS-1:0] avg_next;

    assign acc_sum  = acc_q + ACC_W'(q_code);
    assign avg_next = ADC_BITS'(acc_sum >> LOG2N);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sat_acc_d   = sat_acc_q;
        last_code_d = q_code;
        avg_code_d  = avg_code_q;
        i_est_d     = i_est_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d     = '0;
                    sat_acc_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = (SETTLE_CYC == 0) ? ACQ : SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SET_LAST) begin
                    cnt_d   = '0;
                    state_d = ACQ;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ACQ: begin
                acc_d     = acc_sum;
                sat_acc_d = sat_acc_q | q_clip;
                if (cnt_q == ACQ_LAST) begin
                    // Result registers load together so the handshake sees a coherent set.
                    cnt_d       = '0;
                    state_d     = HOLD;
                    avg_code_d  = avg_next;
                    i_est_d     = (VREF_LO + real'(avg_next) * LSB) / RF_OHM;
                    sat_d       = sat_acc_q | q_clip;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            HOLD: begin
                if (ob.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SETTLE) || (state_d == ACQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            sat_acc_q   <= 1'b0;
            last_code_q <= '0;
            avg_code_q  <= '0;
            i_est_q     <= 0.0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sat_acc_q   <= sat_acc_d;
            last_code_q <= last_code_d;
            avg_code_q  <= avg_code_d;
            i_est_q     <= i_est_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign last_code    = last_code_q;
    assign busy         = busy_q;
    assign ob.out_valid = out_valid_q;
    assign ob.avg_code  = avg_code_q;
    assign ob.i_est     = i_est_q;
    assign ob.sat       = sat_q;
endmodule
